// File: rtl/axis_i2c_ctrl_if.sv
// AXI-Stream command channel used to hand I2C transactions to the controller.
interface axis_i2c_ctrl_if #(
    parameter int DW = 16
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_i2c_ctrl.sv
// Single-master I2C controller driven by one AXI-Stream command per transaction.
// Command: {addr[6:0], rw, data}; reads return the byte on i2c_data_o.
module axis_i2c_ctrl #(
    parameter int I2C_DATA_WIDTH  = 8,
    parameter int AXIS_DATA_WIDTH = I2C_DATA_WIDTH + 8,
    parameter int QDIV            = 250
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    axis_i2c_ctrl_if.slave            s_axis,
    output logic                      i2c_scl,
    output logic                      i2c_sda_en,
    output logic                      wr_bit,
    input  logic                      rd_bit,
    output logic [I2C_DATA_WIDTH-1:0] i2c_data_o
);

    localparam int DW = I2C_DATA_WIDTH;
    localparam int QW = $clog2(QDIV);
    localparam int BW = $clog2((DW > 8) ? DW : 8);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] START     = 4'd1;
    localparam logic [3:0] ADDR      = 4'd2;
    localparam logic [3:0] ADDR_ACK  = 4'd3;
    localparam logic [3:0] WRITE     = 4'd4;
    localparam logic [3:0] WRITE_ACK = 4'd5;
    localparam logic [3:0] READ      = 4'd6;
    localparam logic [3:0] READ_NACK = 4'd7;
    localparam logic [3:0] STOP      = 4'd8;

    logic [3:0]    state;
    logic [QW-1:0] qcnt;
    logic [1:0]    quarter;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    addr_sh;
    logic [DW-1:0] tx_sh;
    logic [DW-1:0] rx_sh;
    logic          rw_r;
    logic          nack_r;
    logic          rdy;

    logic qend;
    logic q2_end;
    logic slot_end;
    logic last_addr;
    logic last_data;

    assign qend      = (qcnt == QW'(QDIV - 1));
    assign q2_end    = qend && (quarter == 2'd2);
    assign slot_end  = qend && (quarter == 2'd3);
    assign last_addr = (bit_cnt == BW'(7));
    assign last_data = (bit_cnt == BW'(DW - 1));

    assign s_axis.tready = rdy;
    // Open-drain: the pad is only ever pulled low, never driven high.
    assign wr_bit = 1'b0;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            qcnt       <= '0;
            quarter    <= '0;
            bit_cnt    <= '0;
            addr_sh    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rw_r       <= 1'b0;
            nack_r     <= 1'b0;
            rdy        <= 1'b0;
            i2c_data_o <= '0;
        end else if (state == IDLE) begin
            qcnt    <= '0;
            quarter <= '0;
            bit_cnt <= '0;
            if (rdy && s_axis.tvalid) begin
                addr_sh <= s_axis.tdata[AXIS_DATA_WIDTH-1 -: 8];
                rw_r    <= s_axis.tdata[DW];
                tx_sh   <= s_axis.tdata[DW-1:0];
                rdy     <= 1'b0;
                state   <= START;
            end else begin
                rdy <= 1'b1;
            end
        end else begin
            qcnt <= qend ? '0 : qcnt + 1'b1;
            if (qend) begin
                quarter <= quarter + 2'd1;
            end
            // Slave data is taken late in the SCL-high phase.
            if (q2_end) begin
                if (state == ADDR_ACK) begin
                    nack_r <= rd_bit;
                end
                if (state == READ) begin
                    rx_sh <= {rx_sh[DW-2:0], rd_bit};
                end
            end
            if (slot_end) begin
                case (state)
                    START: begin
                        bit_cnt <= '0;
                        state   <= ADDR;
                    end
                    ADDR: begin
                        if (last_addr) begin
                            bit_cnt <= '0;
                            state   <= ADDR_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            addr_sh <= {addr_sh[6:0], 1'b0};
                        end
                    end
                    ADDR_ACK: begin
                        if (nack_r) begin
                            state <= STOP;
                        end else begin
                            state <= rw_r ? READ : WRITE;
                        end
                    end
                    WRITE: begin
                        if (last_data) begin
                            bit_cnt <= '0;
                            state   <= WRITE_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sh   <= {tx_sh[DW-2:0], 1'b0};
                        end
                    end
                    WRITE_ACK: begin
                        state <= STOP;
                    end
                    READ: begin
                        if (last_data) begin
                            bit_cnt <= '0;
                            state   <= READ_NACK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    READ_NACK: begin
                        i2c_data_o <= rx_sh;
                        state      <= STOP;
                    end
                    STOP: begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Bus levels decode straight from state and quarter.
    always_comb begin
        i2c_scl    = 1'b1;
        i2c_sda_en = 1'b1;
        case (state)
            START: begin
                i2c_scl    = (quarter != 2'd3);
                i2c_sda_en = ~quarter[1];
            end
            ADDR: begin
                i2c_scl    = quarter[1];
                i2c_sda_en = addr_sh[7];
            end
            WRITE: begin
                i2c_scl    = quarter[1];
                i2c_sda_en = tx_sh[DW-1];
            end
            ADDR_ACK, WRITE_ACK, READ, READ_NACK: begin
                i2c_scl = quarter[1];
            end
            STOP: begin
                i2c_scl    = (quarter != 2'd0);
                i2c_sda_en = quarter[1];
            end
            default: begin
                i2c_scl    = 1'b1;
                i2c_sda_en = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_i2c_ctrl.sv
// Bench for axis_i2c_ctrl: bus-level slave model plus bit scoreboard.
module tb_axis_i2c_ctrl;

    logic       clk = 1'b0;
    logic       arstn = 1'b1;
    logic       i2c_scl;
    logic       i2c_sda_en;
    logic       wr_bit;
    logic       rd_bit;
    logic [7:0] i2c_data_o;
    logic       sda;

    axis_i2c_ctrl_if #(.DW(16)) s_axis ();

    axis_i2c_ctrl #(
        .I2C_DATA_WIDTH (8),
        .AXIS_DATA_WIDTH(16),
        .QDIV           (2)
    ) dut (
        .clk_i     (clk),
        .arstn_i   (arstn),
        .s_axis    (s_axis.slave),
        .i2c_scl   (i2c_scl),
        .i2c_sda_en(i2c_sda_en),
        .wr_bit    (wr_bit),
        .rd_bit    (rd_bit),
        .i2c_data_o(i2c_data_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       exp_q[$];
    logic       obs_q[$];
    logic [7:0] exp_data = 8'h00;

    // Slave model state
    logic       slave_ack = 1'b1;
    logic [7:0] rd_byte = 8'h00;
    logic       slave_low = 1'b0;
    logic       rd_mode = 1'b0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    logic       skip = 1'b0;
    int         bitn = 99;
    int         starts = 0;
    int         stops = 0;

    assign sda    = (i2c_sda_en ? 1'b1 : wr_bit) & ~slave_low;
    assign rd_bit = sda;

    function automatic logic drive_low(int k);
        if (!slave_ack) return 1'b0;
        if (k == 8) return 1'b1;
        if (rd_mode && k >= 9 && k <= 16) return ~rd_byte[16-k];
        if (!rd_mode && k == 17) return 1'b1;
        return 1'b0;
    endfunction

    // Records each bit as the SDA level held while SCL was high.
    always @(negedge clk) begin
        if (!arstn) begin
            skip      = 1'b0;
            bitn      = 99;
            slave_low = 1'b0;
            pscl      = 1'b1;
            psda      = 1'b1;
        end else begin
            if (pscl && i2c_scl && psda && !sda) begin
                starts++;
                bitn = 0;
                skip = 1'b1;
            end else if (pscl && i2c_scl && !psda && sda) begin
                stops++;
            end
            if (pscl && !i2c_scl) begin
                if (!skip) begin
                    obs_q.push_back(psda);
                    if (bitn == 7) rd_mode = psda;
                    bitn++;
                end
                skip      = 1'b0;
                slave_low = drive_low(bitn);
            end
            pscl = i2c_scl;
            psda = sda;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic issue(input logic [15:0] d, output logic ok);
        int n;
        @(negedge clk);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = d;
        n = 0;
        while (!s_axis.tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        ok = s_axis.tready;
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (!s_axis.tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = 16'h0000;
        arstn = 1'b1;
        #2 arstn = 1'b0;
        #1;
        checks++;
        if (i2c_scl !== 1'b1) begin errors++; $display("FAIL reset scl: got %b want 1", i2c_scl); end
        checks++;
        if (i2c_sda_en !== 1'b1) begin errors++; $display("FAIL reset sda_en: got %b want 1", i2c_sda_en); end
        checks++;
        if (wr_bit !== 1'b0) begin errors++; $display("FAIL reset wr_bit: got %b want 0", wr_bit); end
        checks++;
        if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL reset tready: got %b want 0", s_axis.tready); end
        checks++;
        if (i2c_data_o !== 8'h00) begin errors++; $display("FAIL reset data: got %h want 00", i2c_data_o); end
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL first tready: got %b want 1", s_axis.tready); end
    endtask

    task automatic test_write;
        logic ok, e, o;
        int n, s0, p0;
        slave_ack = 1'b1;
        obs_q.delete();
        s0 = starts;
        p0 = stops;
        push_byte(8'hA0);
        exp_q.push_back(1'b0);
        push_byte(8'hA5);
        exp_q.push_back(1'b0);
        issue(16'hA0A5, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL write accept: got %b want 1", ok); end
        wait_idle(n);
        checks++;
        if (n != 160) begin errors++; $display("FAIL write busy cycles: got %0d want 160", n); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL write bit: got %b want %b", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL write extra bits: got %0d want 0", obs_q.size()); end
        checks++;
        if (starts - s0 != 1 || stops - p0 != 1) begin
            errors++;
            $display("FAIL write start/stop: got %0d/%0d want 1/1", starts - s0, stops - p0);
        end
        checks++;
        if (i2c_data_o !== exp_data) begin errors++; $display("FAIL write data hold: got %h want %h", i2c_data_o, exp_data); end
    endtask

    task automatic test_read;
        logic ok, e, o;
        int n;
        slave_ack = 1'b1;
        rd_byte   = 8'h3C;
        obs_q.delete();
        push_byte(8'hA1);
        exp_q.push_back(1'b0);
        push_byte(8'h3C);
        exp_q.push_back(1'b1);
        exp_data = 8'h3C;
        issue(16'hA100, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL read accept: got %b want 1", ok); end
        wait_idle(n);
        checks++;
        if (n != 160) begin errors++; $display("FAIL read busy cycles: got %0d want 160", n); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL read bit: got %b want %b", o, e); end
        end
        checks++;
        if (i2c_data_o !== exp_data) begin errors++; $display("FAIL read data: got %h want %h", i2c_data_o, exp_data); end
    endtask

    task automatic test_addr_nack;
        logic ok, e, o;
        int n, p0;
        slave_ack = 1'b0;
        obs_q.delete();
        p0 = stops;
        push_byte(8'hA0);
        exp_q.push_back(1'b1);
        issue(16'hA0A5, ok);
        wait_idle(n);
        checks++;
        if (n != 88) begin errors++; $display("FAIL nack busy cycles: got %0d want 88", n); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL nack bit: got %b want %b", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL nack extra bits: got %0d want 0", obs_q.size()); end
        checks++;
        if (stops - p0 != 1) begin errors++; $display("FAIL nack stop: got %0d want 1", stops - p0); end
        checks++;
        if (i2c_data_o !== exp_data) begin errors++; $display("FAIL nack data hold: got %h want %h", i2c_data_o, exp_data); end
        slave_ack = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic e, o;
        int n, s0, p0;
        slave_ack = 1'b1;
        obs_q.delete();
        s0 = starts;
        p0 = stops;
        push_byte(8'hA0);
        exp_q.push_back(1'b0);
        push_byte(8'hA5);
        exp_q.push_back(1'b0);
        push_byte(8'hA2);
        exp_q.push_back(1'b0);
        push_byte(8'h5A);
        exp_q.push_back(1'b0);
        @(negedge clk);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = 16'hA0A5;
        n = 0;
        while (!s_axis.tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        s_axis.tdata = 16'hA25A;
        wait_idle(n);
        checks++;
        if (n != 160) begin errors++; $display("FAIL b2b first busy: got %0d want 160", n); end
        checks++;
        if (stops - p0 != 1) begin errors++; $display("FAIL b2b stop before accept: got %0d want 1", stops - p0); end
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
        wait_idle(n);
        checks++;
        if (n != 160) begin errors++; $display("FAIL b2b second busy: got %0d want 160", n); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b bit: got %b want %b", o, e); end
        end
        checks++;
        if (starts - s0 != 2) begin errors++; $display("FAIL b2b starts: got %0d want 2", starts - s0); end
    endtask

    task automatic test_reset_mid;
        logic ok, e, o;
        int n, s0;
        slave_ack = 1'b1;
        issue(16'hA0A5, ok);
        repeat (100) @(negedge clk);
        arstn = 1'b0;
        #1;
        checks++;
        if (i2c_scl !== 1'b1) begin errors++; $display("FAIL midrst scl: got %b want 1", i2c_scl); end
        checks++;
        if (i2c_sda_en !== 1'b1) begin errors++; $display("FAIL midrst sda_en: got %b want 1", i2c_sda_en); end
        checks++;
        if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL midrst tready: got %b want 0", s_axis.tready); end
        exp_data = 8'h00;
        checks++;
        if (i2c_data_o !== exp_data) begin errors++; $display("FAIL midrst data: got %h want %h", i2c_data_o, exp_data); end
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        obs_q.delete();
        exp_q.delete();
        s0 = starts;
        push_byte(8'hA0);
        exp_q.push_back(1'b0);
        push_byte(8'hA5);
        exp_q.push_back(1'b0);
        issue(16'hA0A5, ok);
        wait_idle(n);
        checks++;
        if (n != 160) begin errors++; $display("FAIL post-reset busy: got %0d want 160", n); end
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
            checks++;
            if (o !== e) begin errors++; $display("FAIL post-reset bit: got %b want %b", o, e); end
        end
        checks++;
        if (starts - s0 != 1) begin errors++; $display("FAIL post-reset starts: got %0d want 1", starts - s0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
